// File: rtl/instruction_fetch_unit.sv
// Instruction fetch unit: requests one word at a time from instruction memory,
// latches it into IR, waits for downstream to consume it, and supports redirects.
module instruction_fetch_unit #(
  parameter logic [31:0] RESET_PC = 32'h0000_0000,
  parameter logic [31:0] PC_STEP  = 32'd1
) (
  input  logic        clk,
  input  logic        Reset,
  output logic        MemReq,
  output logic [31:0] MemAddr,
  input  logic        MemReady,
  input  logic [31:0] MemData,
  input  logic        PCLoad,
  input  logic [31:0] PCLoadValue,
  output logic [31:0] IR,
  output logic        IRValid,
  input  logic        IRAccept,
  output logic [1:0]  InstructionFormat,
  output logic [1:0]  Extend,
  output logic [31:0] PC
);

  typedef enum logic [1:0] {
    S_IDLE     = 2'd0,
    S_WAIT_MEM = 2'd1,
    S_HOLD     = 2'd2
  } state_t;

  state_t      r_state;
  state_t      w_state_next;
  logic [31:0] r_pc;
  logic [31:0] w_pc_next;
  logic [31:0] r_ir;
  logic [31:0] w_ir_next;
  logic        r_ir_valid;
  logic        w_ir_valid_next;
  logic [1:0]  w_format;
  logic [1:0]  w_extend;

  always_ff @(posedge clk) begin
    if (Reset) begin
      r_state    <= S_IDLE;
      r_pc       <= RESET_PC;
      r_ir       <= 32'h0;
      r_ir_valid <= 1'b0;
    end else begin
      r_state    <= w_state_next;
      r_pc       <= w_pc_next;
      r_ir       <= w_ir_next;
      r_ir_valid <= w_ir_valid_next;
    end
  end

  // A redirect wins over memory data and over IRAccept, and always passes
  // through IDLE so the new address is never requested in the same cycle.
  always_comb begin
    w_state_next    = r_state;
    w_pc_next       = r_pc;
    w_ir_next       = r_ir;
    w_ir_valid_next = r_ir_valid;
    if (PCLoad) begin
      w_state_next    = S_IDLE;
      w_pc_next       = PCLoadValue;
      w_ir_valid_next = 1'b0;
    end else begin
      case (r_state)
        S_IDLE: begin
          w_state_next = S_WAIT_MEM;
        end
        S_WAIT_MEM: begin
          if (MemReady) begin
            w_ir_next       = MemData;
            w_pc_next       = r_pc + PC_STEP;
            w_ir_valid_next = 1'b1;
            w_state_next    = S_HOLD;
          end
        end
        S_HOLD: begin
          if (IRAccept) begin
            w_ir_valid_next = 1'b0;
            w_state_next    = S_WAIT_MEM;
          end
        end
        default: begin
          w_state_next    = S_IDLE;
          w_ir_valid_next = 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    w_format = 2'd1;
    case (r_ir[5:4])
      2'b00:   w_format = 2'd0;
      2'b11:   w_format = 2'd2;
      default: w_format = 2'd1;
    endcase
    w_extend = (w_format == 2'd0) ? 2'd0 : {1'b0, r_ir[3]};
  end

  assign MemReq            = (r_state == S_WAIT_MEM);
  assign MemAddr           = r_pc;
  assign PC                = r_pc;
  assign IR                = r_ir;
  assign IRValid           = r_ir_valid;
  assign InstructionFormat = w_format;
  assign Extend            = w_extend;

endmodule

// File: tb/tb_instruction_fetch_unit.sv
// Scenario-driven bench for instruction_fetch_unit; expected fetch results are
// queued when memory data is driven and compared when IR becomes valid.
module tb_instruction_fetch_unit;

  localparam logic [31:0] RESET_PC = 32'h0000_0000;
  localparam logic [31:0] PC_STEP  = 32'd1;

  typedef struct packed {
    logic [31:0] ir;
    logic [31:0] pc;
  } exp_t;

  logic        clk = 1'b0;
  logic        Reset;
  logic        MemReq;
  logic [31:0] MemAddr;
  logic        MemReady;
  logic [31:0] MemData;
  logic        PCLoad;
  logic [31:0] PCLoadValue;
  logic [31:0] IR;
  logic        IRValid;
  logic        IRAccept;
  logic [1:0]  InstructionFormat;
  logic [1:0]  Extend;
  logic [31:0] PC;

  int   n_vec = 0;
  int   n_err = 0;
  exp_t sb_q[$];

  instruction_fetch_unit #(
    .RESET_PC(RESET_PC),
    .PC_STEP (PC_STEP)
  ) dut (
    .clk              (clk),
    .Reset            (Reset),
    .MemReq           (MemReq),
    .MemAddr          (MemAddr),
    .MemReady         (MemReady),
    .MemData          (MemData),
    .PCLoad           (PCLoad),
    .PCLoadValue      (PCLoadValue),
    .IR               (IR),
    .IRValid          (IRValid),
    .IRAccept         (IRAccept),
    .InstructionFormat(InstructionFormat),
    .Extend           (Extend),
    .PC               (PC)
  );

  always #5 clk = ~clk;

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  function automatic logic [1:0] exp_fmt(input logic [31:0] d);
    if (d[5:4] == 2'b00) return 2'd0;
    if (d[5:4] == 2'b11) return 2'd2;
    return 2'd1;
  endfunction

  function automatic logic [1:0] exp_ext(input logic [31:0] d);
    if (exp_fmt(d) == 2'd0) return 2'd0;
    return {1'b0, d[3]};
  endfunction

  task automatic wait_req();
    int k;
    for (k = 0; k < 10 && MemReq !== 1'b1; k++) step();
    if (MemReq !== 1'b1) begin
      n_vec++; n_err++;
      $display("FAIL wait_req: MemReq=%b after %0d cycles, required 1", MemReq, k);
    end
  endtask

  // Fetch one word at exp_addr, then check IR/PC/decode against the scoreboard.
  task automatic fetch(input logic [31:0] d, input logic [31:0] exp_addr);
    exp_t e;
    wait_req();
    n_vec++;
    if (MemAddr !== exp_addr) begin
      n_err++; $display("FAIL fetch_addr: MemAddr=%h required %h", MemAddr, exp_addr);
    end
    MemReady = 1'b1; MemData = d;
    sb_q.push_back('{ir: d, pc: exp_addr + PC_STEP});
    step();
    MemReady = 1'b0; MemData = 32'h0;
    n_vec++;
    if (IRValid !== 1'b1 || MemReq !== 1'b0) begin
      n_err++; $display("FAIL fetch_valid: IRValid=%b MemReq=%b required 1/0", IRValid, MemReq);
    end
    if (IRValid === 1'b1 && sb_q.size() > 0) begin
      e = sb_q.pop_front();
      n_vec++;
      if (IR !== e.ir || PC !== e.pc) begin
        n_err++; $display("FAIL fetch_ir_pc: IR=%h PC=%h required %h %h", IR, PC, e.ir, e.pc);
      end
      n_vec++;
      if (InstructionFormat !== exp_fmt(e.ir) || Extend !== exp_ext(e.ir)) begin
        n_err++;
        $display("FAIL decode: fmt=%0d ext=%0d required %0d %0d for IR=%h",
                 InstructionFormat, Extend, exp_fmt(e.ir), exp_ext(e.ir), e.ir);
      end
    end
    $display("fetch data=%h addr=%h -> IR=%h PC=%h fmt=%0d ext=%0d",
             d, exp_addr, IR, PC, InstructionFormat, Extend);
  endtask

  task automatic accept();
    IRAccept = 1'b1;
    step();
    IRAccept = 1'b0;
  endtask

  task automatic test_reset();
    Reset = 1'b1; MemReady = 1'b1; MemData = 32'hFFFF_FFFF;
    PCLoad = 1'b1; PCLoadValue = 32'h55; IRAccept = 1'b0;
    step(); step();
    PCLoad = 1'b0; MemReady = 1'b0; MemData = 32'h0;
    n_vec++;
    if (MemReq !== 1'b0 || PC !== RESET_PC || IR !== 32'h0 || IRValid !== 1'b0) begin
      n_err++;
      $display("FAIL reset_state: MemReq=%b PC=%h IR=%h IRValid=%b required 0/%h/0/0",
               MemReq, PC, IR, IRValid, RESET_PC);
    end
    Reset = 1'b0;
    step();
    n_vec++;
    if (MemReq !== 1'b1 || MemAddr !== RESET_PC) begin
      n_err++; $display("FAIL reset_first_req: MemReq=%b MemAddr=%h required 1/%h", MemReq, MemAddr, RESET_PC);
    end
    $display("reset done MemReq=%b PC=%h", MemReq, PC);
  endtask

  task automatic test_basic();
    fetch(32'h0000_0015, 32'h0);
    n_vec++;
    if (IR !== 32'h15 || InstructionFormat !== 2'd1 || Extend !== 2'd0 || PC !== 32'd1) begin
      n_err++;
      $display("FAIL basic: IR=%h fmt=%0d ext=%0d PC=%h required 15/1/0/1", IR, InstructionFormat, Extend, PC);
    end
  endtask

  task automatic test_hold();
    for (int i = 0; i < 5; i++) begin
      step();
      n_vec++;
      if (IR !== 32'h15 || PC !== 32'd1 || MemReq !== 1'b0 || IRValid !== 1'b1) begin
        n_err++;
        $display("FAIL hold_%0d: IR=%h PC=%h MemReq=%b IRValid=%b required 15/1/0/1", i, IR, PC, MemReq, IRValid);
      end
    end
    accept();
    n_vec++;
    if (MemReq !== 1'b1 || MemAddr !== 32'd1 || IRValid !== 1'b0 || IR !== 32'h15) begin
      n_err++;
      $display("FAIL hold_accept: MemReq=%b MemAddr=%h IRValid=%b IR=%h required 1/1/0/15",
               MemReq, MemAddr, IRValid, IR);
    end
    $display("hold then accept: MemReq=%b MemAddr=%h", MemReq, MemAddr);
  endtask

  task automatic test_stall();
    IRAccept = 1'b1;
    for (int i = 0; i < 3; i++) begin
      step();
      n_vec++;
      if (MemReq !== 1'b1 || MemAddr !== 32'd1 || IRValid !== 1'b0) begin
        n_err++;
        $display("FAIL stall_%0d: MemReq=%b MemAddr=%h IRValid=%b required 1/1/0", i, MemReq, MemAddr, IRValid);
      end
    end
    IRAccept = 1'b0;
    $display("stall: MemAddr=%h held", MemAddr);
  endtask

  task automatic test_decode();
    logic [31:0] tbl [3];
    tbl[0] = 32'h0000_0038;
    tbl[1] = 32'h0000_0008;
    tbl[2] = 32'h0000_0028;
    for (int i = 0; i < 3; i++) begin
      fetch(tbl[i], 32'd1 + i);
      accept();
    end
  endtask

  task automatic test_redirect();
    wait_req();
    PCLoad = 1'b1; PCLoadValue = 32'h100; MemReady = 1'b1; MemData = 32'hDEAD_BEEF;
    step();
    PCLoad = 1'b0; MemReady = 1'b0; MemData = 32'h0;
    n_vec++;
    if (IRValid !== 1'b0 || MemReq !== 1'b0 || PC !== 32'h100 || IR === 32'hDEAD_BEEF) begin
      n_err++;
      $display("FAIL redirect_bubble: IRValid=%b MemReq=%b PC=%h IR=%h required 0/0/100/not-dropped-data",
               IRValid, MemReq, PC, IR);
    end
    step();
    n_vec++;
    if (MemReq !== 1'b1 || MemAddr !== 32'h100) begin
      n_err++; $display("FAIL redirect_req: MemReq=%b MemAddr=%h required 1/100", MemReq, MemAddr);
    end
    $display("redirect to %h", MemAddr);
    fetch(32'h0000_0030, 32'h100);
  endtask

  task automatic test_wrap();
    PCLoad = 1'b1; PCLoadValue = 32'hFFFF_FFFF; IRAccept = 1'b1;
    step();
    PCLoad = 1'b0; IRAccept = 1'b0;
    n_vec++;
    if (IRValid !== 1'b0 || PC !== 32'hFFFF_FFFF || MemReq !== 1'b0) begin
      n_err++;
      $display("FAIL wrap_redirect: IRValid=%b PC=%h MemReq=%b required 0/ffffffff/0", IRValid, PC, MemReq);
    end
    fetch(32'h1234_5600, 32'hFFFF_FFFF);
    n_vec++;
    if (PC !== 32'h0) begin
      n_err++; $display("FAIL wrap_pc: PC=%h required 0", PC);
    end
    accept();
  endtask

  task automatic test_back_to_back();
    logic [31:0] a;
    a = PC;
    for (int i = 0; i < 6; i++) begin
      fetch($urandom, a);
      a = a + PC_STEP;
      accept();
    end
  endtask

  task automatic test_reset_midfetch();
    wait_req();
    Reset = 1'b1; MemReady = 1'b1; MemData = 32'hCAFE_F00D;
    step();
    Reset = 1'b0; MemReady = 1'b0; MemData = 32'h0;
    n_vec++;
    if (IRValid !== 1'b0 || PC !== RESET_PC || IR !== 32'h0 || MemReq !== 1'b0) begin
      n_err++;
      $display("FAIL reset_midfetch: IRValid=%b PC=%h IR=%h MemReq=%b required 0/%h/0/0",
               IRValid, PC, IR, MemReq, RESET_PC);
    end
    $display("reset mid-fetch: PC=%h IR=%h", PC, IR);
    fetch(32'h0000_0010, RESET_PC);
  endtask

  initial begin
    test_reset();
    test_basic();
    test_hold();
    test_stall();
    test_decode();
    test_redirect();
    test_wrap();
    test_back_to_back();
    test_reset_midfetch();
    n_vec++;
    if (sb_q.size() != 0) begin
      n_err++; $display("FAIL scoreboard_drain: %0d entries left, required 0", sb_q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
